// File: rtl/noc_router_output.sv
// NoC router output port: per-VC packet-atomic round-robin arbitration, per-VC FIFOs, link mux.
// Define NOC_ROUTER_OUTPUT_ASSERT_EN to compile in simulation-only protocol assertions.
module noc_router_output #(
   parameter int unsigned FLIT_WIDTH   = 32,
   parameter int unsigned VCHANNELS    = 1,
   parameter int unsigned INPUTS       = 1,
   parameter int unsigned BUFFER_DEPTH = 4
) (
   input  logic                                            clk,
   input  logic                                            rst_n,
   input  logic [VCHANNELS-1:0][INPUTS-1:0][FLIT_WIDTH-1:0] in_flit,
   input  logic [VCHANNELS-1:0][INPUTS-1:0]                in_last,
   input  logic [VCHANNELS-1:0][INPUTS-1:0]                in_valid,
   output logic [VCHANNELS-1:0][INPUTS-1:0]                in_ready,
   output logic [FLIT_WIDTH-1:0]                           out_flit,
   output logic                                            out_last,
   output logic [VCHANNELS-1:0]                            out_valid,
   input  logic [VCHANNELS-1:0]                            out_ready
);
   localparam int unsigned IW = (INPUTS > 1) ? $clog2(INPUTS) : 1;
   localparam int unsigned VW = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;
   localparam int unsigned AW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = FLIT_WIDTH + 1;

   typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_e;

   // Returns {found, index} of the first set request searching cyclically from ptr
   function automatic logic [IW:0] rr_pick(input logic [INPUTS-1:0] req, input logic [IW-1:0] ptr);
      logic [IW:0] res;
      int          idx;
      res = '0;
      for (int k = int'(INPUTS) - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= int'(INPUTS)) idx = idx - int'(INPUTS);
         if (req[idx]) res = {1'b1, IW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [VW:0] vc_pick(input logic [VCHANNELS-1:0] req, input logic [VW-1:0] ptr);
      logic [VW:0] res;
      int          idx;
      res = '0;
      for (int k = int'(VCHANNELS) - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= int'(VCHANNELS)) idx = idx - int'(VCHANNELS);
         if (req[idx]) res = {1'b1, VW'(idx)};
      end
      return res;
   endfunction

   function automatic logic [IW-1:0] inc_in(input logic [IW-1:0] x);
      return (int'(x) == int'(INPUTS) - 1) ? '0 : IW'(int'(x) + 1);
   endfunction

   function automatic logic [VW-1:0] inc_vc(input logic [VW-1:0] x);
      return (int'(x) == int'(VCHANNELS) - 1) ? '0 : VW'(int'(x) + 1);
   endfunction

   logic [VCHANNELS-1:0]         w_empty;
   logic [VCHANNELS-1:0]         w_rd;
   logic [VCHANNELS-1:0][EW-1:0] w_head;

   for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
      arb_state_e        r_state, w_state_nxt;
      logic [IW-1:0]     r_ptr, w_ptr_nxt, r_owner, w_owner_nxt, w_src;
      logic [IW:0]       w_pick;
      logic              w_src_ok, w_full, w_wr;
      logic [INPUTS-1:0] w_rdy;
      logic [EW-1:0]     w_wdata;
      logic [EW-1:0]     r_mem [BUFFER_DEPTH];
      logic [PW-1:0]     r_wp, r_rp;

      // Candidate input: the locked owner, otherwise the round-robin pick
      always_comb begin
         w_pick   = rr_pick(in_valid[v], r_ptr);
         w_src    = (r_state == ST_LOCKED) ? r_owner : w_pick[IW-1:0];
         w_src_ok = (r_state == ST_LOCKED) || w_pick[IW];
      end

      assign w_full  = (r_wp - r_rp) == PW'(BUFFER_DEPTH);
      assign w_wdata = {in_last[v][w_src], in_flit[v][w_src]};
      assign w_wr    = |(w_rdy & in_valid[v]);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
         end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_owner <= w_owner_nxt;
         end
      end

      always_comb begin
         w_state_nxt = r_state;
         w_ptr_nxt   = r_ptr;
         w_owner_nxt = r_owner;
         if (w_wr) begin
            if (w_wdata[EW-1]) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = inc_in(w_src);
            end else begin
               w_state_nxt = ST_LOCKED;
               w_owner_nxt = w_src;
            end
         end
      end

      // Full FIFO blocks all inputs; a simultaneous link pop does not free a slot this cycle
      always_comb begin
         w_rdy = '0;
         if (rst_n && w_src_ok && !w_full) w_rdy[w_src] = 1'b1;
      end
      assign in_ready[v] = w_rdy;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
         end else begin
            if (w_wr)    r_wp <= r_wp + PW'(1);
            if (w_rd[v]) r_rp <= r_rp + PW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (w_wr) r_mem[r_wp[AW-1:0]] <= w_wdata;
      end

      assign w_empty[v] = (r_wp == r_rp);
      assign w_head[v]  = r_mem[r_rp[AW-1:0]];

`ifdef NOC_ROUTER_OUTPUT_ASSERT_EN
      logic                  r_a_own_stall;
      logic [FLIT_WIDTH-1:0] r_a_own_flit;
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_a_own_stall <= 1'b0;
            r_a_own_flit  <= '0;
         end else begin
            r_a_own_stall <= (r_state == ST_LOCKED) && in_valid[v][r_owner] && !w_rdy[r_owner];
            r_a_own_flit  <= in_flit[v][r_owner];
         end
      end
      always @(posedge clk) begin
         if (rst_n && w_wr && w_full) $error("write to full FIFO on VC %0d", v);
         if (rst_n && r_a_own_stall && (!in_valid[v][r_owner] || in_flit[v][r_owner] != r_a_own_flit))
            $error("owner input changed while stalled on VC %0d", v);
      end
`endif
   end

   logic [VW:0]   w_vpick;
   logic [VW-1:0] w_vsel, r_lock_vc, r_vptr;
   logic          w_vsel_ok, r_lock;

   // Link mux: a stalled selection is held, otherwise round-robin over non-empty VCs
   always_comb begin
      w_vpick   = vc_pick(~w_empty, r_vptr);
      w_vsel    = r_lock ? r_lock_vc : w_vpick[VW-1:0];
      w_vsel_ok = r_lock || w_vpick[VW];
      out_valid = '0;
      out_flit  = '0;
      out_last  = 1'b0;
      w_rd      = '0;
      if (w_vsel_ok) begin
         out_valid[w_vsel]    = 1'b1;
         {out_last, out_flit} = w_head[w_vsel];
         w_rd[w_vsel]         = out_ready[w_vsel];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lock    <= 1'b0;
         r_lock_vc <= '0;
         r_vptr    <= '0;
      end else begin
         r_lock    <= w_vsel_ok && !out_ready[w_vsel];
         r_lock_vc <= w_vsel;
         if (w_vsel_ok && out_ready[w_vsel]) r_vptr <= inc_vc(w_vsel);
      end
   end

`ifdef NOC_ROUTER_OUTPUT_ASSERT_EN
   logic                 r_a_stall;
   logic [VCHANNELS-1:0] r_a_valid;
   logic [EW-1:0]        r_a_data;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_stall <= 1'b0;
         r_a_valid <= '0;
         r_a_data  <= '0;
      end else begin
         r_a_stall <= |(out_valid & ~out_ready);
         r_a_valid <= out_valid;
         r_a_data  <= {out_last, out_flit};
      end
   end
   always @(posedge clk) begin
      if (rst_n && !$onehot0(out_valid)) $error("out_valid not at most one-hot: %b", out_valid);
      if (rst_n && r_a_stall && (out_valid != r_a_valid || {out_last, out_flit} != r_a_data))
         $error("link output changed while stalled");
   end
`endif
endmodule

// File: tb/tb_noc_router_output.sv
// Bench for noc_router_output: directed vector table, hand sequences and random traffic vs a reference model.
module tb_noc_router_output;
   localparam int FW    = 16;
   localparam int NVC   = 2;
   localparam int NI    = 3;
   localparam int DEPTH = 4;
   localparam int NT    = 23;

   logic clk = 1'b0;
   logic rst_n;
   logic [NVC-1:0][NI-1:0][FW-1:0] in_flit;
   logic [NVC-1:0][NI-1:0]         in_last, in_valid, in_ready;
   logic [FW-1:0]                  out_flit;
   logic                           out_last;
   logic [NVC-1:0]                 out_valid, out_ready;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   noc_router_output #(
      .FLIT_WIDTH(FW), .VCHANNELS(NVC), .INPUTS(NI), .BUFFER_DEPTH(DEPTH)
   ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_flit(in_flit), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
      .out_flit(out_flit), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FW-1:0] mkf(input int v, input int i, input int s);
      return {4'(v), 4'(i), 8'(s)};
   endfunction

   // ---------------- reference model: per-VC queues, owner (-1 = none), rr pointers
   logic [FW:0] m_buf [NVC][DEPTH];
   int m_head [NVC];
   int m_cnt  [NVC];
   int m_owner[NVC];
   int m_ptr  [NVC];
   int m_vptr, m_held, e_sel;
   logic [NVC-1:0][NI-1:0]         e_rdy, c_valid, c_last;
   logic [NVC-1:0][NI-1:0][FW-1:0] c_flit;
   logic [NVC-1:0]                 e_ov, c_ordy;
   logic [FW-1:0]                  e_flit;
   logic                           e_last;

   task automatic model_reset();
      for (int v = 0; v < NVC; v++) begin
         m_head[v] = 0; m_cnt[v] = 0; m_owner[v] = -1; m_ptr[v] = 0;
      end
      m_vptr = 0; m_held = -1;
   endtask

   task automatic model_expect();
      e_rdy = '0;
      for (int v = 0; v < NVC; v++) begin
         if (m_cnt[v] < DEPTH) begin
            if (m_owner[v] >= 0) e_rdy[v][m_owner[v]] = 1'b1;
            else begin
               for (int k = 0; k < NI; k++) begin
                  if (in_valid[v][(m_ptr[v] + k) % NI]) begin
                     e_rdy[v][(m_ptr[v] + k) % NI] = 1'b1;
                     break;
                  end
               end
            end
         end
      end
      e_sel = m_held;
      if (e_sel < 0) begin
         for (int k = 0; k < NVC; k++) begin
            if (m_cnt[(m_vptr + k) % NVC] > 0) begin
               e_sel = (m_vptr + k) % NVC;
               break;
            end
         end
      end
      e_ov = '0; e_flit = '0; e_last = 1'b0;
      if (e_sel >= 0) begin
         e_ov[e_sel] = 1'b1;
         {e_last, e_flit} = m_buf[e_sel][m_head[e_sel]];
      end
   endtask

   task automatic model_update();
      if (e_sel >= 0) begin
         if (c_ordy[e_sel]) begin
            m_head[e_sel] = (m_head[e_sel] + 1) % DEPTH;
            m_cnt[e_sel]--;
            m_vptr = (e_sel + 1) % NVC;
            m_held = -1;
         end else m_held = e_sel;
      end
      for (int v = 0; v < NVC; v++) begin
         for (int i = 0; i < NI; i++) begin
            if (e_rdy[v][i] && c_valid[v][i]) begin
               m_buf[v][(m_head[v] + m_cnt[v]) % DEPTH] = {c_last[v][i], c_flit[v][i]};
               m_cnt[v]++;
               if (c_last[v][i]) begin
                  m_owner[v] = -1;
                  m_ptr[v] = (i + 1) % NI;
               end else m_owner[v] = i;
            end
         end
      end
   endtask

   // Continuous comparison of every DUT output against the model
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
            chk("mon_rst_in_ready", 64'(in_ready), 64'(0));
            chk("mon_rst_out_valid", 64'(out_valid), 64'(0));
            chk("mon_rst_out_flit", 64'(out_flit), 64'(0));
            chk("mon_rst_out_last", 64'(out_last), 64'(0));
         end else begin
            model_expect();
            c_valid = in_valid; c_last = in_last; c_flit = in_flit; c_ordy = out_ready;
            chk("mon_in_ready", 64'(in_ready), 64'(e_rdy));
            chk("mon_out_valid", 64'(out_valid), 64'(e_ov));
            chk("mon_out_flit", 64'(out_flit), 64'(e_flit));
            chk("mon_out_last", 64'(out_last), 64'(e_last));
            @(posedge clk);
            if (rst_n) model_update();
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers
   logic [NVC-1:0][NI-1:0] acc;

   task automatic to_neg();
      @(negedge clk);
      acc = in_valid & in_ready;
   endtask

   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = '0; in_last = '0; in_flit = '0; out_ready = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      acc = '0;
   endtask

   typedef struct {
      logic          rst;
      logic [NI-1:0] v;
      logic [NI-1:0] l;
      logic [NVC-1:0] ordy;
      logic [NI-1:0] erdy;
      logic [NVC-1:0] eov;
      logic          elast;
   } vec_t;

   vec_t tbl [NT];
   logic [FW-1:0] got [$];
   int seq;
   int rem [NVC][NI];
   int sq  [NVC][NI];
   logic [NVC-1:0] alt_ordy [9];
   logic [NVC-1:0] alt_ov   [9];
   logic [FW-1:0]  alt_flit [9];

   initial begin
      // two 3-flit packets (inputs 0 and 1): atomic, input 0 first
      tbl[0]  = '{1'b1, 3'b011, 3'b000, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[1]  = '{1'b0, 3'b011, 3'b000, 2'b01, 3'b001, 2'b01, 1'b0};
      tbl[2]  = '{1'b0, 3'b011, 3'b001, 2'b01, 3'b001, 2'b01, 1'b0};
      tbl[3]  = '{1'b0, 3'b010, 3'b000, 2'b01, 3'b010, 2'b01, 1'b1};
      tbl[4]  = '{1'b0, 3'b010, 3'b000, 2'b01, 3'b010, 2'b01, 1'b0};
      tbl[5]  = '{1'b0, 3'b010, 3'b010, 2'b01, 3'b010, 2'b01, 1'b0};
      tbl[6]  = '{1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b01, 1'b1};
      tbl[7]  = '{1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b00, 1'b0};
      // owner 0 drops valid for 4 cycles; input 1 must wait
      tbl[8]  = '{1'b1, 3'b011, 3'b000, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[9]  = '{1'b0, 3'b010, 3'b000, 2'b01, 3'b001, 2'b01, 1'b0};
      tbl[10] = '{1'b0, 3'b010, 3'b000, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[11] = '{1'b0, 3'b010, 3'b000, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[12] = '{1'b0, 3'b010, 3'b000, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[13] = '{1'b0, 3'b011, 3'b001, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[14] = '{1'b0, 3'b010, 3'b010, 2'b01, 3'b010, 2'b01, 1'b1};
      tbl[15] = '{1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b01, 1'b1};
      tbl[16] = '{1'b0, 3'b000, 3'b000, 2'b01, 3'b000, 2'b00, 1'b0};
      // three inputs, continuous single-flit packets: grants wrap 0,1,2,0,1,2
      tbl[17] = '{1'b1, 3'b111, 3'b111, 2'b01, 3'b001, 2'b00, 1'b0};
      tbl[18] = '{1'b0, 3'b111, 3'b111, 2'b01, 3'b010, 2'b01, 1'b1};
      tbl[19] = '{1'b0, 3'b111, 3'b111, 2'b01, 3'b100, 2'b01, 1'b1};
      tbl[20] = '{1'b0, 3'b111, 3'b111, 2'b01, 3'b001, 2'b01, 1'b1};
      tbl[21] = '{1'b0, 3'b111, 3'b111, 2'b01, 3'b010, 2'b01, 1'b1};
      tbl[22] = '{1'b0, 3'b111, 3'b111, 2'b01, 3'b100, 2'b01, 1'b1};

      do_reset();
      rst_n = 1'b0;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'(0));
      chk("reset_in_ready", 64'(in_ready), 64'(0));
      to_drive();
      rst_n = 1'b1;

      for (int n = 0; n < NT; n++) begin
         if (tbl[n].rst) do_reset();
         in_valid[0] = tbl[n].v;
         in_last[0]  = tbl[n].l;
         out_ready   = tbl[n].ordy;
         for (int i = 0; i < NI; i++) in_flit[0][i] = mkf(0, i, n);
         to_neg();
         chk($sformatf("tbl%0d_in_ready", n), 64'(in_ready[0]), 64'(tbl[n].erdy));
         chk($sformatf("tbl%0d_out_valid", n), 64'(out_valid), 64'(tbl[n].eov));
         chk($sformatf("tbl%0d_out_last", n), 64'(out_last), 64'(tbl[n].elast));
         to_drive();
      end

      // backpressure: 6-flit packet into a 4-deep FIFO with the link stalled
      do_reset();
      seq = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid[0][0] = 1'b1;
         in_flit[0][0]  = mkf(0, 0, seq);
         in_last[0][0]  = (seq == 5);
         to_neg();
         if (acc[0][0]) seq++;
         if (c == 7) chk("bp_in_ready_full", 64'(in_ready[0]), 64'(0));
         to_drive();
      end
      chk("bp_accepted", 64'(seq), 64'(4));
      out_ready = 2'b01;
      got.delete();
      for (int c = 0; c < 30 && got.size() < 6; c++) begin
         in_valid[0][0] = (seq < 6);
         in_flit[0][0]  = mkf(0, 0, seq);
         in_last[0][0]  = (seq == 5);
         to_neg();
         if (acc[0][0]) seq++;
         if (out_valid[0] && out_ready[0]) got.push_back(out_flit);
         to_drive();
      end
      chk("bp_total_accepted", 64'(seq), 64'(6));
      chk("bp_link_count", 64'(got.size()), 64'(6));
      for (int k = 0; k < 6 && k < got.size(); k++)
         chk($sformatf("bp_link_order%0d", k), 64'(got[k]), 64'(mkf(0, 0, k)));
      in_valid = '0;

      // VC interleave and held selection under partial out_ready
      do_reset();
      for (int c = 0; c < 3; c++) begin
         in_valid[0][0] = 1'b1; in_valid[1][0] = 1'b1;
         in_last[0][0]  = 1'b1; in_last[1][0]  = 1'b1;
         in_flit[0][0]  = mkf(0, 0, c); in_flit[1][0] = mkf(1, 0, c);
         to_neg();
         to_drive();
      end
      in_valid = '0;
      alt_ordy = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
      alt_ov   = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      alt_flit = '{mkf(0,0,0), mkf(1,0,0), mkf(1,0,0), mkf(1,0,0), mkf(1,0,0),
                   mkf(0,0,1), mkf(1,0,1), mkf(0,0,2), mkf(1,0,2)};
      for (int c = 0; c < 9; c++) begin
         out_ready = alt_ordy[c];
         to_neg();
         chk($sformatf("vc_alt%0d_valid", c), 64'(out_valid), 64'(alt_ov[c]));
         chk($sformatf("vc_alt%0d_flit", c), 64'(out_flit), 64'(alt_flit[c]));
         to_drive();
      end
      out_ready = 2'b11;
      to_neg();
      chk("vc_alt_drained", 64'(out_valid), 64'(0));
      to_drive();

      // asynchronous reset with a partial packet buffered
      do_reset();
      for (int c = 0; c < 2; c++) begin
         in_valid[0][0] = 1'b1; in_last[0][0] = 1'b0; in_flit[0][0] = mkf(0, 0, c);
         to_neg();
         to_drive();
      end
      chk("mid_pre_out_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
      to_drive();
      in_valid = '0;
      rst_n = 1'b1;
      in_valid[0][1] = 1'b1; in_last[0][1] = 1'b1; in_flit[0][1] = mkf(0, 1, 9);
      out_ready = 2'b01;
      to_neg();
      chk("mid_post_in_ready", 64'(in_ready[0]), 64'(3'b010));
      to_drive();
      in_valid = '0;
      to_neg();
      chk("mid_post_out_valid", 64'(out_valid), 64'(1));
      chk("mid_post_out_flit", 64'(out_flit), 64'(mkf(0, 1, 9)));
      chk("mid_post_out_last", 64'(out_last), 64'(1));
      to_drive();
      to_neg();
      chk("mid_post_empty", 64'(out_valid), 64'(0));
      to_drive();

      // random traffic: sources hold while stalled, may pause between flits
      do_reset();
      for (int v = 0; v < NVC; v++)
         for (int i = 0; i < NI; i++) begin
            rem[v][i] = 0; sq[v][i] = 0;
         end
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int v = 0; v < NVC; v++) begin
            for (int i = 0; i < NI; i++) begin
               if (in_valid[v][i] && acc[v][i]) begin
                  sq[v][i]++;
                  rem[v][i]--;
                  if (rem[v][i] == 0 || $urandom_range(3) == 0) in_valid[v][i] = 1'b0;
               end
               if (!in_valid[v][i] && $urandom_range(1) == 0) begin
                  if (rem[v][i] == 0) rem[v][i] = int'($urandom_range(4, 1));
                  in_valid[v][i] = 1'b1;
               end
               in_flit[v][i] = mkf(v, i, sq[v][i]);
               in_last[v][i] = (rem[v][i] == 1);
            end
         end
         out_ready = 2'($urandom);
         to_neg();
         to_drive();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
